mult_product_accumulator: RTL and testbench

Downstream consumer of the 4x4 array multiplier's 8-bit product. Sums a programmed number of products into a wide register (dot-product / MAC back end), then holds the result and flags completion. Products are accepted over a valid/ready handshake so the operand-sequencing logic can stall freely.

---
 rtl/mult_product_accumulator.sv | 118 +++++++++++
 tb/tb_mult_product_accumulator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_product_accumulator.sv
// rtl/mult_product_accumulator.sv - sums a programmed number of 8-bit products into a wide accumulator
//
// Purpose: back end of a dot-product / MAC datapath. A run is opened with
// start (which samples len), then len products are accepted over a
// valid/ready handshake and added into sum. When the last product has been
// added the block pulses done for one cycle and holds sum/overflow until the
// next start or reset.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   start       open a new run (also aborts a run in progress)
//   len         number of products in the run (0 completes immediately)
//   prod        unsigned product from the multiplier
//   prod_valid  prod is valid this cycle
//   prod_ready  block accepts prod this cycle
//   sum         running / final accumulated value
//   busy        run in progress
//   done        one-cycle completion pulse, sum is final while high
//   overflow    sticky for the current run: accumulator wrapped

module mult_product_accumulator #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] sum,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    logic             accept;
    // One extra bit on the adder captures the carry out of the accumulator.
    logic [ACC_W:0]   add_w;

    assign add_w = {1'b0, sum_q} + {{(ACC_W - 7){1'b0}}, prod};

    // start wins over a simultaneous product, so ready is masked by start.
    assign prod_ready = (state_q == S_ACC) && !start;
    assign accept     = prod_ready && prod_valid;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_ACC: begin
                if (accept) begin
                    sum_d = add_w[ACC_W-1:0];
                    ovf_d = ovf_q | add_w[ACC_W];
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // start behaves identically in every state: it restarts the run.
        // In DONE the done pulse is still produced this cycle because done
        // decodes the current state.
        if (start) begin
            sum_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = len;
            state_d = (len == '0) ? S_DONE : S_ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum      = sum_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == S_ACC);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_mult_product_accumulator.sv
// tb/tb_mult_product_accumulator.sv - scoreboard bench for mult_product_accumulator

module tb_mult_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  len = 4'd0;
    logic [7:0]  prod = 8'd0;
    logic        prod_valid = 1'b0;

    logic        ready_a, busy_a, done_a, ovf_a;
    logic [15:0] sum_a;
    logic        ready_b, busy_b, done_b, ovf_b;
    logic [7:0]  sum_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int s16;
        int o16;
        int s8;
        int o8;
    } exp_t;

    exp_t sb[$];
    int   prods[16];
    int   gaps[16];

    always #5 clk = ~clk;

    mult_product_accumulator #(.ACC_W(16), .LEN_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(ready_a), .sum(sum_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a)
    );

    mult_product_accumulator #(.ACC_W(8), .LEN_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(ready_b), .sum(sum_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the run's result is the plain integer sum of its products;
    // a W-bit accumulator shows that sum mod 2^W and has wrapped iff the
    // total reached 2^W (products are non-negative, so the sum is monotonic).
    task automatic push_expected(input int n);
        exp_t e;
        int   total = 0;
        for (int i = 0; i < n; i++) total += prods[i];
        e.s16 = total % 65536;
        e.o16 = (total >= 65536) ? 1 : 0;
        e.s8  = total % 256;
        e.o8  = (total >= 256) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input int n);
        start      = 1'b1;
        len        = 4'(n);
        prod_valid = 1'($urandom);
        prod       = 8'($urandom);
        #1;
        check("ready_low_on_start", ready_a, 0);
        tick();
        start      = 1'b0;
        prod_valid = 1'b0;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                prod_valid = 1'b0;
                prod       = 8'($urandom);
                tick();
            end
            prod_valid = 1'b1;
            prod       = 8'(prods[i]);
            #1;
            check("ready_in_acc", ready_a, 1);
            tick();
        end
        prod_valid = 1'b0;
    endtask

    task automatic end_run();
        check("done_timing", done_a, 1);
        check("done_timing8", done_b, 1);
        tick();
        check("done_one_cycle", done_a, 0);
        check("busy_after_done", busy_a, 0);
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < 16; i++) gaps[i] = 0;
    endtask

    // Monitor: pops one expected result for every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_rule", ready_a, (busy_a && !start) ? 1 : 0);
            check("done_match", done_b, done_a);
            if (done_a) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending run at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum16", sum_a, e.s16);
                    check("ovf16", ovf_a, e.o16);
                    check("sum8", sum_b, e.s8);
                    check("ovf8", ovf_b, e.o8);
                end
            end
        end
    end

    initial begin
        clear_gaps();

        // Reset with random inputs on the pins.
        for (int i = 0; i < 3; i++) begin
            start      = 1'($urandom);
            len        = 4'($urandom);
            prod       = 8'($urandom);
            prod_valid = 1'($urandom);
            tick();
            check("rst_sum", sum_a, 0);
            check("rst_busy", busy_a, 0);
            check("rst_done", done_a, 0);
            check("rst_ovf", ovf_a, 0);
            check("rst_ready", ready_a, 0);
        end
        start      = 1'b0;
        prod_valid = 1'b1;
        rst_n      = 1'b1;
        repeat (3) tick();
        check("idle_sum", sum_a, 0);
        check("idle_ready", ready_a, 0);
        check("idle_busy", busy_a, 0);
        prod_valid = 1'b0;

        // len=3, back-to-back 225, 100, 1 -> 326.
        prods[0] = 225; prods[1] = 100; prods[2] = 1;
        push_expected(3);
        begin_run(3);
        feed(3);
        check("sum_326", sum_a, 326);
        end_run();

        // len=2 with valid on cycles 1 and 5 -> 16, done on cycle 6.
        prods[0] = 7; prods[1] = 9; gaps[1] = 3;
        push_expected(2);
        begin_run(2);
        feed(2);
        end_run();
        clear_gaps();

        // len=0 -> done next cycle, sum 0.
        push_expected(0);
        begin_run(0);
        end_run();

        // 8-bit wrap: 200 + 100 -> 44 with overflow; next start clears it.
        prods[0] = 200; prods[1] = 100;
        push_expected(2);
        begin_run(2);
        feed(2);
        check("wrap_sum8", sum_b, 44);
        check("wrap_ovf8", ovf_b, 1);
        end_run();
        check("ovf_hold", ovf_b, 1);
        prods[0] = 3;
        push_expected(1);
        begin_run(1);
        check("ovf_cleared", ovf_b, 0);
        feed(1);
        end_run();

        // Abort: len=4, two accepts, then start len=1 with a product present.
        prods[0] = 50; prods[1] = 50;
        begin_run(4);
        feed(2);
        check("abort_partial", sum_a, 100);
        prods[0] = 9;
        push_expected(1);
        start      = 1'b1;
        len        = 4'd1;
        prod_valid = 1'b1;
        prod       = 8'd77;
        #1;
        check("abort_ready", ready_a, 0);
        tick();
        start      = 1'b0;
        prod_valid = 1'b0;
        check("abort_clear", sum_a, 0);
        feed(1);
        end_run();

        // Reset mid-run: back to reset values, no done pulse.
        prods[0] = 40; prods[1] = 60;
        begin_run(5);
        feed(2);
        rst_n = 1'b0;
        #2;
        check("midrst_sum", sum_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_ready", ready_a, 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("midrst_done", done_a, 0);

        // start during the DONE cycle: done still pulses, new run begins.
        prods[0] = 5;
        push_expected(1);
        begin_run(1);
        feed(1);
        check("done_before_restart", done_a, 1);
        prods[0] = 3; prods[1] = 4;
        push_expected(2);
        begin_run(2);
        check("start_in_done", busy_a, 1);
        feed(2);
        end_run();

        // Randomized runs with random gaps.
        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                prods[i] = $urandom_range(0, 15) * $urandom_range(0, 15);
                if ((r % 3) == 0) prods[i] = $urandom_range(0, 255);
                gaps[i] = $urandom_range(0, 2);
            end
            push_expected(n);
            begin_run(n);
            feed(n);
            end_run();
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
